// File: rtl/sha256_block_padder.sv
// sha256_block_padder
// Byte-stream front end for the SHA-256 core. Packs input beats into 64-byte
// blocks, applies SHA-256 padding (0x80, zero fill, 64-bit big-endian bit
// length) and hands 512-bit blocks to the core over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_FILL | accepting beats into the byte buffer (i_ready=1, cnt < 64)
// S_EMIT | data block presented on o_block, waiting for o_ready
// S_PAD  | extra padding-only block presented, waiting for o_ready
module sha256_block_padder #(
    parameter int IN_BYTES = 1,
    parameter int LEN_W    = 64,
    localparam int IBW     = $clog2(IN_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [8*IN_BYTES-1:0] i_data,
    input  logic                  i_last,
    input  logic [IBW-1:0]        i_bytes,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [511:0]          o_block,
    output logic                  o_first,
    output logic                  o_last
);

    typedef enum logic [1:0] {
        S_FILL,
        S_EMIT,
        S_PAD
    } state_t;

    state_t           state;
    logic [6:0]       cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       buf_q [64];
    logic             first_q;     // next emitted block starts a message
    logic             need_pad_q;  // EMIT block is followed by a PAD block
    logic             pad_lead_q;  // PAD block begins with the 0x80 marker

    logic [6:0]       beat_nb;
    logic [6:0]       fill_n;
    logic [6:0]       pos;
    logic [LEN_W-1:0] len_d;
    logic [63:0]      len64_d;
    logic [63:0]      len64_q;
    logic [7:0]       buf_d [64];
    logic [511:0]     data_blk;
    logic [511:0]     pad_blk;

    // Byte count of the current beat (clamped on a short last beat) and the resulting fill/length.
    always_comb begin
        if (i_last) begin
            beat_nb = (7'(i_bytes) > 7'(IN_BYTES)) ? 7'(IN_BYTES) : 7'(i_bytes);
        end else begin
            beat_nb = 7'(IN_BYTES);
        end
        fill_n  = cnt_q + beat_nb;
        len_d   = len_q + (LEN_W'(beat_nb) << 3);
        len64_d = 64'(len_d);
        len64_q = 64'(len_q);
    end

    // Merge the valid lanes of the incoming beat into the buffer at offset cnt.
    always_comb begin
        buf_d = buf_q;
        pos   = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            pos = cnt_q + 7'(k);
            if ((7'(k) < beat_nb) && !pos[6]) begin
                buf_d[pos[5:0]] = i_data[8*(IN_BYTES-1-k) +: 8];
            end
        end
    end

    // Assemble the outgoing data block (with padding on a last beat) and the padding-only block.
    always_comb begin
        data_blk = '0;
        pad_blk  = '0;
        for (int j = 0; j < 64; j++) begin
            if (!i_last || (7'(j) < fill_n)) begin
                data_blk[8*(63-j) +: 8] = buf_d[j];
            end else if (7'(j) == fill_n) begin
                data_blk[8*(63-j) +: 8] = 8'h80;
            end
        end
        for (int j = 56; j < 64; j++) begin
            if (i_last && (fill_n <= 7'd55)) begin
                data_blk[8*(63-j) +: 8] = len64_d[8*(63-j) +: 8];
            end
            pad_blk[8*(63-j) +: 8] = len64_q[8*(63-j) +: 8];
        end
        if (pad_lead_q) begin
            pad_blk[511:504] = 8'h80;
        end
    end

    // Control FSM with registered handshake outputs and block register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FILL;
            cnt_q      <= '0;
            len_q      <= '0;
            first_q    <= 1'b1;
            need_pad_q <= 1'b0;
            pad_lead_q <= 1'b0;
            i_ready    <= 1'b0;
            o_valid    <= 1'b0;
            o_block    <= '0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            for (int j = 0; j < 64; j++) begin
                buf_q[j] <= '0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    i_ready <= 1'b1;
                    if (i_valid && i_ready) begin
                        buf_q <= buf_d;
                        len_q <= len_d;
                        if (i_last || (fill_n == 7'd64)) begin
                            cnt_q      <= '0;
                            o_block    <= data_blk;
                            o_valid    <= 1'b1;
                            o_first    <= first_q;
                            first_q    <= 1'b0;
                            o_last     <= i_last && (fill_n <= 7'd55);
                            need_pad_q <= i_last && (fill_n >= 7'd56);
                            pad_lead_q <= (fill_n == 7'd64);
                            i_ready    <= 1'b0;
                            state      <= S_EMIT;
                        end else begin
                            cnt_q <= fill_n;
                        end
                    end
                end
                S_EMIT: begin
                    if (o_ready) begin
                        o_first <= 1'b0;
                        if (need_pad_q) begin
                            o_block <= pad_blk;
                            o_last  <= 1'b1;
                            state   <= S_PAD;
                        end else begin
                            if (o_last) begin
                                len_q   <= '0;
                                first_q <= 1'b1;
                            end
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            i_ready <= 1'b1;
                            state   <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (o_ready) begin
                        len_q      <= '0;
                        first_q    <= 1'b1;
                        need_pad_q <= 1'b0;
                        o_valid    <= 1'b0;
                        o_last     <= 1'b0;
                        i_ready    <= 1'b1;
                        state      <= S_FILL;
                    end
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Bench for sha256_block_padder with 4-byte beats: directed padding corner
// cases, backpressure, resets mid-message/mid-block and random messages,
// compared against a queue-based SHA-256 padding model.
module tb_sha256_block_padder;

    localparam int IB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           i_valid;
    logic           i_ready;
    logic [8*IB-1:0] i_data;
    logic           i_last;
    logic [2:0]     i_bytes;
    logic           o_valid;
    logic           o_ready = 1'b0;
    logic [511:0]   o_block;
    logic           o_first;
    logic           o_last;

    int n_cmp = 0;
    int n_err = 0;
    int ready_mode = 0;   // 0 random, 1 held low, 2 held high

    logic [511:0] got_blk[$];
    logic         got_first[$];
    logic         got_last[$];
    logic [511:0] seen_blk[$];
    logic [511:0] exp_blk[$];
    logic         exp_first[$];
    logic         exp_last[$];

    sha256_block_padder #(.IN_BYTES(IB), .LEN_W(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_bytes (i_bytes),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_block (o_block),
        .o_first (o_first),
        .o_last  (o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Reference: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length, split into blocks.
    task automatic model(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        logic [511:0] b;
        int nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 0; i < 8; i++) p.push_back(bits[63-8*i -: 8]);
        nb = p.size() / 64;
        exp_blk.delete(); exp_first.delete(); exp_last.delete();
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k+j];
            exp_blk.push_back(b);
            exp_first.push_back(k == 0);
            exp_last.push_back(k == nb - 1);
        end
    endtask

    // Sink: choose o_ready for the coming edge, record handshakes, check stall stability.
    initial begin
        logic         prev_stall;
        logic [511:0] prev_blk;
        prev_stall = 1'b0;
        prev_blk   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 512'(o_valid), 512'(1));
                    chk("hold_blk", o_block, prev_blk);
                end
                case (ready_mode)
                    1:       o_ready = 1'b0;
                    2:       o_ready = 1'b1;
                    default: o_ready = ($urandom_range(0, 2) != 0);
                endcase
                if (o_valid && o_ready) begin
                    got_blk.push_back(o_block);
                    got_first.push_back(o_first);
                    got_last.push_back(o_last);
                end
                prev_stall = o_valid && !o_ready;
                prev_blk   = o_block;
            end
        end
    end

    task automatic drive_beat(input logic [8*IB-1:0] d, input logic l, input logic [2:0] nb);
        int t;
        t = 0;
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        i_bytes = nb;
        while (!i_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!i_ready) chk("beat_timeout", 512'(i_ready), 512'(1));
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_data  = $urandom;
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int len, nfull, r, pos, cntb;
        logic zero_last;
        logic [8*IB-1:0] d;
        len = msg.size();
        zero_last = (len > 0) && (len % IB == 0) && ($urandom_range(0, 1) == 1);
        nfull = zero_last ? len / IB : ((len == 0) ? 0 : (len - 1) / IB);
        r = len - nfull * IB;
        pos = 0;
        for (int b = 0; b <= nfull; b++) begin
            cntb = (b < nfull) ? IB : r;
            d = $urandom;
            for (int k = 0; k < cntb; k++) d[8*IB-1-8*k -: 8] = msg[pos+k];
            pos += cntb;
            if (b < nfull) drive_beat(d, 1'b0, 3'($urandom_range(0, 7)));
            else if (r == IB) drive_beat(d, 1'b1, 3'($urandom_range(IB, 7)));
            else drive_beat(d, 1'b1, 3'(r));
        end
    endtask

    task automatic clear_got();
        got_blk.delete(); got_first.delete(); got_last.delete();
    endtask

    task automatic run_msg(input string tag, input logic [7:0] msg[$]);
        int n_exp, t;
        model(msg);
        n_exp = exp_blk.size();
        send_msg(msg);
        t = 0;
        while (got_blk.size() < n_exp && t < 4000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk($sformatf("%s_nblk", tag), 512'(got_blk.size()), 512'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (i < got_blk.size()) begin
                chk($sformatf("%s_blk%0d", tag, i), got_blk[i], exp_blk[i]);
                chk($sformatf("%s_first%0d", tag, i), 512'(got_first[i]), 512'(exp_first[i]));
                chk($sformatf("%s_last%0d", tag, i), 512'(got_last[i]), 512'(exp_last[i]));
            end
        end
        seen_blk = got_blk;
        clear_got();
    endtask

    task automatic fill_msg(output logic [7:0] m[$], input int len, input int kind);
        m.delete();
        for (int i = 0; i < len; i++) begin
            if (kind == 0) m.push_back(8'h61);
            else if (kind == 1) m.push_back(8'(i));
            else m.push_back(8'($urandom));
        end
    endtask

    initial begin
        logic [7:0]   m[$];
        logic [511:0] k;
        logic [511:0] cap;
        int t;

        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   m[$];
        logic [511:0] k;
        logic [511:0] cap;
        int t;

        rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_bytes = '0;
        repeat (3) @(negedge clk);
        chk("rst_ovalid", 512'(o_valid), 512'(0));
        chk("rst_iready", 512'(i_ready), 512'(0));
        chk("rst_oblock", o_block, 512'(0));
        chk("rst_ofirst", 512'(o_first), 512'(0));
        chk("rst_olast", 512'(o_last), 512'(0));
        rst = 1'b0;
        @(negedge clk);

        // "abc"
        m.delete(); m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        run_msg("abc", m);
        k = '0; k[511:480] = 32'h61626380; k[63:0] = 64'h18;
        if (seen_blk.size() > 0) chk("abc_const", seen_blk[0], k);

        // empty message
        m.delete();
        run_msg("empty", m);
        k = '0; k[511:504] = 8'h80;
        if (seen_blk.size() > 0) chk("empty_const", seen_blk[0], k);

        fill_msg(m, 55, 0);
        run_msg("len55", m);
        if (seen_blk.size() > 0) chk("len55_tail", 512'(seen_blk[0][63:0]), 512'(64'h1B8));

        fill_msg(m, 56, 0);
        run_msg("len56", m);
        k = '0; k[63:0] = 64'h1C0;
        if (seen_blk.size() > 1) chk("len56_pad", seen_blk[1], k);

        for (int rep = 0; rep < 2; rep++) begin
            fill_msg(m, 64, 1);
            run_msg("len64", m);
            k = '0; k[511:504] = 8'h80; k[63:0] = 64'h200;
            if (seen_blk.size() > 1) chk("len64_pad", seen_blk[1], k);
        end

        fill_msg(m, 71, 2);
        run_msg("len71", m);
        if (seen_blk.size() > 1) begin
            chk("len71_mark", 512'(seen_blk[1][455:448]), 512'(8'h80));
            chk("len71_len", 512'(seen_blk[1][63:0]), 512'(64'h238));
        end

        // backpressure during EMIT
        ready_mode = 1;
        fill_msg(m, 20, 2);
        model(m);
        send_msg(m);
        t = 0;
        while (!o_valid && t < 50) begin @(negedge clk); t++; end
        cap = o_block;
        chk("bp_blk", cap, exp_blk[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 512'(o_valid), 512'(1));
            chk("bp_stable", o_block, cap);
            chk("bp_iready", 512'(i_ready), 512'(0));
        end
        ready_mode = 2;
        repeat (8) @(negedge clk);
        chk("bp_count", 512'(got_blk.size()), 512'(1));
        chk("bp_done", 512'(o_valid), 512'(0));
        clear_got();
        ready_mode = 0;

        // reset mid-message and mid-beat
        for (int i = 0; i < 5; i++) drive_beat(32'($urandom), 1'b0, 3'd4);
        i_valid = 1'b1; i_data = $urandom; i_last = 1'b1; i_bytes = 3'd2;
        rst = 1'b1;
        #1;
        chk("rstm_ovalid", 512'(o_valid), 512'(0));
        chk("rstm_iready", 512'(i_ready), 512'(0));
        @(negedge clk);
        i_valid = 1'b0; i_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rstm_noblk", 512'(got_blk.size()), 512'(0));
        clear_got();
        m.delete(); m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        run_msg("post_rst", m);

        // reset while a block is held in EMIT
        ready_mode = 1;
        fill_msg(m, 60, 2);
        send_msg(m);
        t = 0;
        while (!o_valid && t < 50) begin @(negedge clk); t++; end
        chk("rste_pre", 512'(o_valid), 512'(1));
        rst = 1'b1;
        #1;
        chk("rste_ovalid", 512'(o_valid), 512'(0));
        chk("rste_oblock", o_block, 512'(0));
        chk("rste_ofirst", 512'(o_first), 512'(0));
        chk("rste_olast", 512'(o_last), 512'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        clear_got();
        fill_msg(m, 90, 2);
        run_msg("post_rste", m);

        // random messages, back-to-back
        for (int n = 0; n < 30; n++) begin
            ready_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            fill_msg(m, $urandom_range(0, 200), 2);
            run_msg($sformatf("rnd%0d", n), m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
